rx_arb: RTL and testbench

- Collects report packets from CH_NUM rx_phy instances, one per miner chain, and merges them into one word stream toward the shared report FIFO.
- Each rx_phy push is a fixed burst of RX_DATA_LEN words (RXID, TaskID_H, TaskID_L, TIME, NONCE) with no backpressure, so every channel gets a one-packet holding buffer.
- Full buffers are drained round-robin under the FIFO almost-full flag.
- Packets that cannot be buffered are dropped and counted.

---
 rtl/rx_arb_pkg.sv | 21 ++
 rtl/rx_arb_chbuf.sv | 92 +++++++++
 rtl/rx_arb.sv | 184 ++++++++++++++++++
 tb/tb_rx_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_arb_pkg.sv
// Shared constants and state encodings for the rx_phy report arbiter.
package rx_arb_pkg;

  localparam int RX_DATA_LEN = 5;

  typedef enum logic [1:0] {
    CAP_EMPTY = 2'd0,
    CAP_FILL  = 2'd1,
    CAP_FULL  = 2'd2
  } cap_state_e;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_SEND = 1'b1
  } out_state_e;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_arb_chbuf.sv
// One-packet holding buffer for a single rx_phy channel.
//   state     | meaning
//   CAP_EMPTY | no packet held, waiting for rx_start
//   CAP_FILL  | collecting burst words into the array
//   CAP_FULL  | complete packet held until the drain side releases it
module rx_arb_chbuf #(
  parameter int RX_DATA_LEN = rx_arb_pkg::RX_DATA_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_start,
  input  logic        i_vld,
  input  logic        i_last,
  input  logic [31:0] i_dat,
  input  logic [2:0]  i_rd_idx,
  input  logic        i_release,
  output logic [31:0] o_rd_dat,
  output logic        o_full,
  output logic        o_busy,
  output logic        o_drop
);
  import rx_arb_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(RX_DATA_LEN - 1);

  cap_state_e  r_state;
  cap_state_e  w_state_nxt;
  logic [2:0]  r_wr_idx;
  logic [2:0]  w_wr_idx_nxt;
  logic        w_wr_en;
  logic [31:0] r_mem [RX_DATA_LEN];

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_idx_nxt = r_wr_idx;
    w_wr_en      = 1'b0;
    o_drop       = 1'b0;
    if (i_flush) begin
      w_state_nxt  = CAP_EMPTY;
      w_wr_idx_nxt = '0;
    end else begin
      case (r_state)
        CAP_EMPTY: begin
          if (i_start) begin
            w_state_nxt  = CAP_FILL;
            w_wr_idx_nxt = '0;
          end
        end
        CAP_FILL: begin
          if (i_vld && (int'(r_wr_idx) < RX_DATA_LEN)) begin
            w_wr_en      = 1'b1;
            w_wr_idx_nxt = r_wr_idx + 3'd1;
          end
          // a burst that ends early is malformed and is thrown away
          if (i_last) begin
            if (r_wr_idx == LAST_IDX) begin
              w_state_nxt = CAP_FULL;
            end else begin
              w_state_nxt = CAP_EMPTY;
              o_drop      = 1'b1;
            end
          end
        end
        CAP_FULL: begin
          if (i_start) o_drop = 1'b1;
          if (i_release) w_state_nxt = CAP_EMPTY;
        end
        default: w_state_nxt = CAP_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= CAP_EMPTY;
      r_wr_idx <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_idx <= w_wr_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_idx] <= i_dat;
  end

  assign o_rd_dat = r_mem[i_rd_idx];
  assign o_full   = (r_state == CAP_FULL);
  assign o_busy   = (r_state != CAP_EMPTY);

endmodule

// File: rtl/rx_arb.sv
// Merges per-channel rx_phy report packets into one word stream toward the report FIFO.
//   state    | meaning
//   OUT_IDLE | no packet granted; pick next FULL buffer round-robin from rr_ptr
//   OUT_SEND | streaming the granted buffer, one word per cycle without afull
module rx_arb #(
  parameter  int CH_NUM      = 4,
  parameter  int RX_DATA_LEN = rx_arb_pkg::RX_DATA_LEN,
  localparam int CH_W        = rx_arb_pkg::ch_idx_w(CH_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reg_flush,
  input  logic [CH_NUM-1:0]    rx_start,
  input  logic [CH_NUM-1:0]    rx_vld,
  input  logic [CH_NUM-1:0]    rx_last,
  input  logic [32*CH_NUM-1:0] rx_dat,
  input  logic                 fifo_afull,
  output logic                 out_vld,
  output logic [31:0]          out_dat,
  output logic                 out_last,
  output logic [CH_W-1:0]      out_ch,
  input  logic                 drop_clr,
  output logic [15:0]          drop_cnt,
  output logic                 busy
);
  import rx_arb_pkg::*;

  localparam logic [2:0]      LAST_IDX = 3'(RX_DATA_LEN - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CH_NUM - 1);

  out_state_e        r_state;
  out_state_e        w_state_nxt;
  logic [CH_W-1:0]   r_gnt;
  logic [CH_W-1:0]   w_gnt_nxt;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   w_rr_nxt;
  logic [CH_W-1:0]   w_arb_gnt;
  logic [CH_W:0]     w_scan;
  logic [2:0]        r_rd_idx;
  logic [2:0]        w_rd_idx_nxt;
  logic              w_any_full;
  logic              w_issue;
  logic [CH_NUM-1:0] w_full;
  logic [CH_NUM-1:0] w_nonempty;
  logic [CH_NUM-1:0] w_drop;
  logic [CH_NUM-1:0] w_release;
  logic [31:0]       w_rd_dat [CH_NUM];

  logic              r_out_vld;
  logic              r_out_last;
  logic [31:0]       r_out_dat;
  logic [CH_W-1:0]   r_out_ch;
  logic [15:0]       r_drop_cnt;
  logic [4:0]        w_drop_num;
  logic [16:0]       w_drop_sum;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    rx_arb_chbuf #(
      .RX_DATA_LEN (RX_DATA_LEN)
    ) u_chbuf (
      .clk       (clk),
      .rst       (rst),
      .i_flush   (reg_flush),
      .i_start   (rx_start[c]),
      .i_vld     (rx_vld[c]),
      .i_last    (rx_last[c]),
      .i_dat     (rx_dat[32*c +: 32]),
      .i_rd_idx  (r_rd_idx),
      .i_release (w_release[c]),
      .o_rd_dat  (w_rd_dat[c]),
      .o_full    (w_full[c]),
      .o_busy    (w_nonempty[c]),
      .o_drop    (w_drop[c])
    );
  end

  // rotate the search start to rr_ptr so the last served channel goes to the back
  always_comb begin
    w_any_full = 1'b0;
    w_arb_gnt  = '0;
    w_scan     = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
      if (w_scan >= (CH_W+1)'(CH_NUM)) w_scan = w_scan - (CH_W+1)'(CH_NUM);
      if (!w_any_full && w_full[w_scan[CH_W-1:0]]) begin
        w_any_full = 1'b1;
        w_arb_gnt  = w_scan[CH_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_rd_idx_nxt = r_rd_idx;
    w_rr_nxt     = r_rr_ptr;
    w_issue      = 1'b0;
    w_release    = '0;
    if (reg_flush) begin
      w_state_nxt = OUT_IDLE;
    end else begin
      case (r_state)
        OUT_IDLE: begin
          if (w_any_full) begin
            w_state_nxt  = OUT_SEND;
            w_gnt_nxt    = w_arb_gnt;
            w_rd_idx_nxt = '0;
            w_rr_nxt     = (w_arb_gnt == LAST_CH) ? '0 : w_arb_gnt + 1'b1;
          end
        end
        OUT_SEND: begin
          if (!fifo_afull) begin
            w_issue = 1'b1;
            if (r_rd_idx == LAST_IDX) begin
              w_release[r_gnt] = 1'b1;
              w_state_nxt      = OUT_IDLE;
            end else begin
              w_rd_idx_nxt = r_rd_idx + 3'd1;
            end
          end
        end
        default: w_state_nxt = OUT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= OUT_IDLE;
      r_gnt    <= '0;
      r_rd_idx <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rd_idx <= w_rd_idx_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_dat  <= '0;
      r_out_ch   <= '0;
    end else begin
      r_out_vld  <= w_issue;
      r_out_last <= w_issue && (r_rd_idx == LAST_IDX);
      if (w_issue) begin
        r_out_dat <= w_rd_dat[r_gnt];
        r_out_ch  <= r_gnt;
      end
    end
  end

  always_comb begin
    w_drop_num = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      w_drop_num = w_drop_num + 5'(w_drop[k]);
    end
    w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_num);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (drop_clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop_sum[16]) begin
      r_drop_cnt <= 16'hFFFF;
    end else begin
      r_drop_cnt <= w_drop_sum[15:0];
    end
  end

  assign out_vld  = r_out_vld;
  assign out_dat  = r_out_dat;
  assign out_last = r_out_last;
  assign out_ch   = r_out_ch;
  assign drop_cnt = r_drop_cnt;
  assign busy     = (r_state != OUT_IDLE) || (|w_nonempty);

endmodule

// File: tb/tb_rx_arb.sv
// Directed bench for rx_arb: capture, round-robin drain, backpressure, drops, flush and reset.
module tb_rx_arb;

  logic         clk;
  logic         rst;
  logic         reg_flush;
  logic [3:0]   rx_start;
  logic [3:0]   rx_vld;
  logic [3:0]   rx_last;
  logic [127:0] rx_dat;
  logic         fifo_afull;
  logic         out_vld;
  logic [31:0]  out_dat;
  logic         out_last;
  logic [1:0]   out_ch;
  logic         drop_clr;
  logic [15:0]  drop_cnt;
  logic         busy;

  int n_checks;
  int n_errors;

  rx_arb #(.CH_NUM(4), .RX_DATA_LEN(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_flush  (reg_flush),
    .rx_start   (rx_start),
    .rx_vld     (rx_vld),
    .rx_last    (rx_last),
    .rx_dat     (rx_dat),
    .fifo_afull (fifo_afull),
    .out_vld    (out_vld),
    .out_dat    (out_dat),
    .out_last   (out_last),
    .out_ch     (out_ch),
    .drop_clr   (drop_clr),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start one cycle, then nwords vld cycles with rx_last on the final one; word = base + sep*ch + i
  task automatic push(input logic [3:0] mask, input logic [31:0] base,
                      input logic [31:0] sep, input int nwords);
    rx_start = mask;
    tick();
    rx_start = '0;
    for (int i = 0; i < nwords; i++) begin
      rx_vld  = mask;
      rx_last = (i == nwords - 1) ? mask : 4'b0000;
      for (int c = 0; c < 4; c++) rx_dat[32*c +: 32] = base + sep * c + i;
      tick();
    end
    rx_vld  = '0;
    rx_last = '0;
  endtask

  task automatic chk_word(input string tag, input int ch, input logic [31:0] dat, input bit last);
    chk({tag, "_vld"}, 64'(out_vld), 64'd1);
    chk({tag, "_dat"}, 64'(out_dat), 64'(dat));
    chk({tag, "_ch"}, 64'(out_ch), 64'(ch));
    chk({tag, "_last"}, 64'(out_last), 64'(last));
  endtask

  task automatic check_words(input string tag, input int ch, input logic [31:0] base);
    for (int i = 0; i < 5; i++) begin
      chk_word(tag, ch, base + i, i == 4);
      tick();
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    reg_flush  = 1'b0;
    rx_start   = '0;
    rx_vld     = '0;
    rx_last    = '0;
    rx_dat     = '0;
    fifo_afull = 1'b0;
    drop_clr   = 1'b0;
    repeat (3) tick();

    chk("rst_vld",  64'(out_vld),  64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_dat",  64'(out_dat),  64'd0);
    chk("rst_ch",   64'(out_ch),   64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_busy", 64'(busy),     64'd0);
    rst = 1'b1;
    tick();

    // all four channels full together, rr_ptr=0: ch0..ch3 with one idle cycle between
    push(4'hF, 32'h1000, 32'h100, 5);
    tick();
    chk("all_lat", 64'(out_vld), 64'd0);
    tick();
    for (int c = 0; c < 4; c++) begin
      check_words("all", c, 32'h1000 + 32'h100 * c);
      chk("all_gap", 64'(out_vld), 64'd0);
      tick();
    end
    chk("all_busy", 64'(busy), 64'd0);

    // rr_ptr wrapped back to 0: ch0 goes before ch1
    push(4'b0011, 32'h2000, 32'h100, 5);
    tick();
    tick();
    check_words("rr0", 0, 32'h2000);
    chk("rr_gap", 64'(out_vld), 64'd0);
    tick();
    check_words("rr1", 1, 32'h2100);
    chk("rr_end", 64'(out_vld), 64'd0);

    // single packet on ch1, words 0xA..0xE, first word two cycles after FULL
    push(4'b0010, 32'hA, 32'h0, 5);
    chk("one_busy", 64'(busy), 64'd1);
    chk("one_lat0", 64'(out_vld), 64'd0);
    tick();
    chk("one_lat1", 64'(out_vld), 64'd0);
    tick();
    check_words("one", 1, 32'hA);
    chk("one_vld_end",  64'(out_vld),  64'd0);
    chk("one_last_end", 64'(out_last), 64'd0);
    chk("one_busy_end", 64'(busy),     64'd0);
    chk("one_drop",     64'(drop_cnt), 64'd0);

    // fifo_afull for 3 cycles after word 2
    push(4'b0001, 32'h30, 32'h0, 5);
    tick();
    tick();
    chk_word("af_w0", 0, 32'h30, 1'b0);
    tick();
    chk_word("af_w1", 0, 32'h31, 1'b0);
    fifo_afull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("af_stall", 64'(out_vld), 64'd0);
    end
    fifo_afull = 1'b0;
    tick();
    chk_word("af_w2", 0, 32'h32, 1'b0);
    tick();
    chk_word("af_w3", 0, 32'h33, 1'b0);
    tick();
    chk_word("af_w4", 0, 32'h34, 1'b1);
    tick();
    chk("af_end", 64'(out_vld), 64'd0);

    // ch2 full and blocked, second packet on ch2 dropped, first delivered intact
    fifo_afull = 1'b1;
    push(4'b0100, 32'h40, 32'h0, 5);
    rx_start = 4'b0100;
    tick();
    rx_start = '0;
    chk("ovf_drop", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < 5; i++) begin
      rx_vld  = 4'b0100;
      rx_last = (i == 4) ? 4'b0100 : 4'b0000;
      rx_dat[64 +: 32] = 32'hDEAD_0000 + i;
      tick();
    end
    rx_vld  = '0;
    rx_last = '0;
    chk("ovf_drop2", 64'(drop_cnt), 64'd1);
    chk("ovf_stall", 64'(out_vld),  64'd0);
    chk("ovf_busy",  64'(busy),     64'd1);
    fifo_afull = 1'b0;
    tick();
    check_words("ovf", 2, 32'h40);
    chk("ovf_end", 64'(out_vld), 64'd0);

    // malformed burst: rx_last after 3 words
    push(4'b1000, 32'h50, 32'h0, 3);
    chk("mal_drop", 64'(drop_cnt), 64'd2);
    chk("mal_busy", 64'(busy),     64'd0);
    tick();
    tick();
    chk("mal_novld", 64'(out_vld), 64'd0);

    // reg_flush while word 3 of ch0 is on the output
    push(4'b0001, 32'h60, 32'h0, 5);
    tick();
    tick();
    chk_word("fl_w0", 0, 32'h60, 1'b0);
    tick();
    chk_word("fl_w1", 0, 32'h61, 1'b0);
    tick();
    chk_word("fl_w2", 0, 32'h62, 1'b0);
    reg_flush = 1'b1;
    tick();
    reg_flush = 1'b0;
    chk("fl_vld",  64'(out_vld),  64'd0);
    chk("fl_last", 64'(out_last), 64'd0);
    chk("fl_busy", 64'(busy),     64'd0);
    chk("fl_dat",  64'(out_dat),  64'h62);
    chk("fl_drop", 64'(drop_cnt), 64'd2);
    tick();
    tick();
    chk("fl_quiet", 64'(out_vld), 64'd0);

    // rr_ptr survived the flush (points at ch1), so ch1 goes before ch0
    push(4'b0011, 32'h70, 32'h100, 5);
    tick();
    tick();
    check_words("flrr1", 1, 32'h170);
    chk("flrr_gap", 64'(out_vld), 64'd0);
    tick();
    check_words("flrr0", 0, 32'h70);

    // drop counter saturation and clear priority
    fifo_afull = 1'b1;
    push(4'hF, 32'h90, 32'h100, 5);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("sat_clr", 64'(drop_cnt), 64'd0);
    rx_start = 4'hF;
    repeat (16383) tick();
    chk("sat_pre", 64'(drop_cnt), 64'd65532);
    rx_start = 4'b0111;
    tick();
    chk("sat_top", 64'(drop_cnt), 64'hFFFF);
    rx_start = 4'hF;
    tick();
    chk("sat_hold", 64'(drop_cnt), 64'hFFFF);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    rx_start = '0;
    chk("sat_clr_prio", 64'(drop_cnt), 64'd0);
    reg_flush  = 1'b1;
    fifo_afull = 1'b0;
    tick();
    reg_flush = 1'b0;
    chk("sat_flush_busy", 64'(busy), 64'd0);

    // async reset in the middle of a packet
    push(4'b0001, 32'h0, 32'h0, 2);
    chk("ar_drop", 64'(drop_cnt), 64'd1);
    push(4'b0010, 32'h80, 32'h0, 5);
    tick();
    tick();
    chk_word("ar_w0", 1, 32'h80, 1'b0);
    tick();
    chk_word("ar_w1", 1, 32'h81, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_vld",  64'(out_vld),  64'd0);
    chk("ar_last", 64'(out_last), 64'd0);
    chk("ar_dat",  64'(out_dat),  64'd0);
    chk("ar_ch",   64'(out_ch),   64'd0);
    chk("ar_drop0", 64'(drop_cnt), 64'd0);
    chk("ar_busy", 64'(busy),     64'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("ar_quiet", 64'(out_vld), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
